// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm game blocks: game states and key codes.
package rhythm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  localparam logic [7:0]  KEY_START  = 8'h2c;
  localparam logic [7:0]  KEY_RETURN = 8'h01;

  // Largest value four BCD digits can hold, in binary.
  localparam logic [13:0] BIN_MAX    = 14'd9999;

endpackage

// File: rtl/bcd_sat_add.sv
// Combinational 4-digit BCD plus binary addend, saturating at 9999.
module bcd_sat_add
  import rhythm_pkg::*;
(
  input  logic [15:0] bcd_in,
  input  logic [13:0] addend,
  output logic [15:0] bcd_out
);

  logic [14:0] bin_sum;
  logic [13:0] bin_sat;
  logic [3:0]  d3, d2, d1, d0;

  // Convert to binary, add, clamp, then split back into decimal digits.
  always_comb begin
    bin_sum = 15'(bcd_in[15:12]) * 15'd1000
            + 15'(bcd_in[11:8])  * 15'd100
            + 15'(bcd_in[7:4])   * 15'd10
            + 15'(bcd_in[3:0])
            + 15'(addend);
    bin_sat = (bin_sum > 15'(BIN_MAX)) ? BIN_MAX : bin_sum[13:0];
    d3      = 4'(bin_sat / 14'd1000);
    d2      = 4'((bin_sat / 14'd100) % 14'd10);
    d1      = 4'((bin_sat / 14'd10) % 14'd10);
    d0      = 4'(bin_sat % 14'd10);
    bcd_out = {d3, d2, d1, d0};
  end

endmodule

// File: rtl/score_tally.sv
// Score keeper for the note droppers: edge-detects hit/done levels, scores
// hits with a combo bonus, counts misses, and runs the Idle/Play/Over flow.
module score_tally
  import rhythm_pkg::*;
#(
  parameter int N_NOTES   = 36,
  parameter int PTS_HIT   = 10,
  parameter int PTS_BONUS = 5,
  parameter int COMBO_TH  = 10
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [N_NOTES-1:0] hit,
  input  logic [N_NOTES-1:0] done,
  output logic [15:0]        score_bcd,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic [7:0]         miss_cnt,
  output logic               game_over
);

  localparam int          CW        = $clog2(N_NOTES + 1);
  localparam logic [31:0] PTS_PLAIN = 32'(PTS_HIT);
  localparam logic [31:0] PTS_BONUS_HIT = 32'(PTS_HIT + PTS_BONUS);
  localparam logic [31:0] TH        = 32'(COMBO_TH);

  game_state_t        state;
  logic [N_NOTES-1:0] hit_q, done_q;
  logic [N_NOTES-1:0] hit_rise, miss_vec;
  logic [CW-1:0]      h_cnt, m_cnt;
  logic [31:0]        pts_raw, combo_sum, miss_sum;
  logic [13:0]        pts_add;
  logic [7:0]         combo_hit, miss_next;
  logic [15:0]        score_next;

  // Rising edges, per-lane misses, and their popcounts for this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    h_cnt    = '0;
    m_cnt    = '0;
    hit_rise = hit & ~hit_q;
    // A done edge with the hit level high is a scored note, not a miss.
    miss_vec = done & ~done_q & ~hit;
    for (int i = 0; i < N_NOTES; i++) begin
      h_cnt = h_cnt + CW'(hit_rise[i]);
      m_cnt = m_cnt + CW'(miss_vec[i]);
    end
  end

  // Points, saturated combo and miss counts that a Play cycle would commit.
  always_comb begin
    pts_raw   = 32'(h_cnt) * ((32'(combo) >= TH) ? PTS_BONUS_HIT : PTS_PLAIN);
    pts_add   = (pts_raw > 32'(BIN_MAX)) ? BIN_MAX : pts_raw[13:0];
    combo_sum = 32'(combo) + 32'(h_cnt);
    combo_hit = (combo_sum > 32'd255) ? 8'hFF : combo_sum[7:0];
    miss_sum  = 32'(miss_cnt) + 32'(m_cnt);
    miss_next = (miss_sum > 32'd255) ? 8'hFF : miss_sum[7:0];
  end

  bcd_sat_add u_bcd_sat_add (
    .bcd_in  (score_bcd),
    .addend  (pts_add),
    .bcd_out (score_next)
  );

  // Game FSM with registered counters; edge registers track inputs in every state.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      hit_q     <= '0;
      done_q    <= '0;
      score_bcd <= '0;
      combo     <= '0;
      max_combo <= '0;
      miss_cnt  <= '0;
      game_over <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hit_q  <= hit;
      done_q <= done;
      case (state)
        ST_IDLE: begin
          if (keycode == KEY_START) begin
            state     <= ST_PLAY;
            score_bcd <= '0;
            combo     <= '0;
            max_combo <= '0;
            miss_cnt  <= '0;
          end
        end
        ST_PLAY: begin
          score_bcd <= score_next;
          miss_cnt  <= miss_next;
          combo     <= (m_cnt != '0) ? 8'h00 : combo_hit;
          if (combo_hit > max_combo) max_combo <= combo_hit;
          if (&done) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
          end
        end
        ST_OVER: begin
          if (keycode == KEY_RETURN) begin
            state     <= ST_IDLE;
            game_over <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_tally.sv
// Self-checking bench for score_tally: directed scenarios plus random
// stimulus compared against a lane-by-lane behavioural score model.
module tb_score_tally;

  localparam int N = 36;

  logic          frame_clk = 1'b0;
  logic          Reset     = 1'b0;
  logic [7:0]    keycode   = 8'h00;
  logic [N-1:0]  hit       = '0;
  logic [N-1:0]  done      = '0;
  logic [15:0]   score_bcd;
  logic [7:0]    combo, max_combo, miss_cnt;
  logic          game_over;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game phase 0=Idle 1=Play 2=Over, plain integer counters.
  int           m_phase;
  int           m_score, m_combo, m_max, m_miss;
  logic [N-1:0] m_prev_hit, m_prev_done;

  score_tally dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .hit       (hit),
    .done      (done),
    .score_bcd (score_bcd),
    .combo     (combo),
    .max_combo (max_combo),
    .miss_cnt  (miss_cnt),
    .game_over (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_combo = 0; m_max = 0; m_miss = 0;
    m_prev_hit = '0; m_prev_done = '0;
  endtask

  // One clock of game rules applied to the inputs present at the edge.
  task automatic model_clock(input logic [N-1:0] h, input logic [N-1:0] d, input logic [7:0] k);
    int hits = 0;
    int misses = 0;
    int per;
    for (int i = 0; i < N; i++) begin
      if (h[i] && !m_prev_hit[i]) hits++;
      if (d[i] && !m_prev_done[i] && !h[i]) misses++;
    end
    m_prev_hit  = h;
    m_prev_done = d;
    case (m_phase)
      0: if (k == 8'h2c) begin
           m_phase = 1; m_score = 0; m_combo = 0; m_max = 0; m_miss = 0;
         end
      1: begin
           per     = (m_combo >= 10) ? 15 : 10;
           m_score = min_int(m_score + hits * per, 9999);
           m_combo = min_int(m_combo + hits, 255);
           if (m_combo > m_max) m_max = m_combo;
           if (misses > 0) begin
             m_combo = 0;
             m_miss  = min_int(m_miss + misses, 255);
           end
           if (d == {N{1'b1}}) m_phase = 2;
         end
      default: if (k == 8'h01) m_phase = 0;
    endcase
  endtask

  task automatic check_all();
    check("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
    check("combo",     32'(combo),     32'(m_combo));
    check("max_combo", 32'(max_combo), 32'(m_max));
    check("miss_cnt",  32'(miss_cnt),  32'(m_miss));
    check("game_over", 32'(game_over), 32'(m_phase == 2));
  endtask

  // Drive one cycle on the falling edge, advance the model at the rising edge, compare after.
  task automatic step(input logic [N-1:0] h, input logic [N-1:0] d, input logic [7:0] k);
    @(negedge frame_clk);
    hit = h; done = d; keycode = k;
    @(posedge frame_clk);
    model_clock(h, d, k);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    hit = '0; done = '0; keycode = 8'h00;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  task automatic new_game();
    do_reset();
    step('0, '0, 8'h2c);
  endtask

  task automatic single_hit(input int lane);
    step(N'(1) << lane, '0, 8'h00);
    step('0, '0, 8'h00);
  endtask

  function automatic logic [N-1:0] rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[N-1:0];
  endfunction

  initial begin
    logic [N-1:0] rh, rd;
    logic [7:0]   rk;
    int           sel;

    // Reset state.
    Reset = 1'b1;
    model_reset();
    #2;
    check_all();
    Reset = 1'b0;

    // Single hit on lane 3, then twelve sequential hits in total.
    new_game();
    step(N'(1) << 3, '0, 8'h00);
    check("first_hit_score", 32'(score_bcd), 32'h0010);
    check("first_hit_combo", 32'(combo),     32'd1);
    step('0, '0, 8'h00);
    for (int i = 0; i < 11; i++) single_hit(3);
    check("twelve_score", 32'(score_bcd), 32'h0130);
    check("twelve_combo", 32'(combo),     32'd12);
    check("twelve_max",   32'(max_combo), 32'd12);

    // Two hit edges and one miss in the same cycle at combo 5.
    new_game();
    for (int i = 0; i < 5; i++) single_hit(3);
    step(36'h3, 36'h4, 8'h00);
    check("mixed_score", 32'(score_bcd), 32'h0070);
    check("mixed_combo", 32'(combo),     32'd0);
    check("mixed_max",   32'(max_combo), 32'd7);
    check("mixed_miss",  32'(miss_cnt),  32'd1);
    step('0, 36'h4, 8'h00);

    // Same-lane hit and done edges together count as a hit.
    step(36'h10, 36'h14, 8'h00);
    check("hit_and_done_combo", 32'(combo),    32'd1);
    check("hit_and_done_miss",  32'(miss_cnt), 32'd1);

    // Game over, return, restart with held levels producing no edges.
    step('0, {N{1'b1}}, 8'h00);
    check("over_flag", 32'(game_over), 32'd1);
    step(36'h3f, 36'h0ff, 8'h00);
    step(36'h3f, 36'h0ff, 8'h01);
    check("back_idle", 32'(game_over), 32'd0);
    step(36'h3f, 36'hf0ff, 8'h2c);
    step(36'h3f, 36'hf0ff, 8'h00);
    check("restart_score", 32'(score_bcd), 32'h0000);
    check("restart_combo", 32'(combo),     32'd0);
    check("restart_miss",  32'(miss_cnt),  32'd0);
    check("restart_max",   32'(max_combo), 32'd0);

    // Asynchronous reset between clock edges mid-game.
    step('0, '0, 8'h00);
    single_hit(7);
    @(posedge frame_clk);
    #3;
    Reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_score", 32'(score_bcd), 32'h0000);
    check("async_rst_combo", 32'(combo),     32'd0);
    check_all();
    @(negedge frame_clk);
    hit = '0; done = '0; keycode = 8'h00;
    Reset = 1'b0;
    step(36'h1, '0, 8'h00);
    check("idle_after_rst", 32'(score_bcd), 32'h0000);

    // Score saturation from bursts of simultaneous hits.
    new_game();
    while (m_score <= 9450) begin
      step({N{1'b1}}, '0, 8'h00);
      step('0, '0, 8'h00);
    end
    while (m_score < 9990) single_hit(0);
    for (int i = 0; i < 3; i++) single_hit(i);
    check("sat_score",  32'(score_bcd), 32'h9999);
    check("sat_combo",  32'(combo),     32'hff);
    check("sat_max",    32'(max_combo), 32'hff);
    step('0, '0, 8'h00);
    check("sat_held",   32'(score_bcd), 32'h9999);

    // Randomized play against the model.
    for (int g = 0; g < 4; g++) begin
      new_game();
      for (int c = 0; c < 250; c++) begin
        sel = $urandom_range(0, 3);
        rh  = (sel == 0) ? rand_vec() : (rand_vec() & rand_vec() & rand_vec());
        rd  = rand_vec() & rand_vec();
        rd[N-1] = 1'b0;
        if ($urandom_range(0, 99) == 0) rd = {N{1'b1}};
        sel = $urandom_range(0, 15);
        rk  = (sel == 0) ? 8'h2c : (sel == 1) ? 8'h01 : 8'h00;
        step(rh, rd, rk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_tally.md
SCORE_TALLY -- requirements
Module: score_tally

Interface
REQ-001 SHALL have parameter N_NOTES, default 36, number of note droppers observed.
REQ-002 SHALL have parameter PTS_HIT, default 10, points per hit.
REQ-003 SHALL have parameter PTS_BONUS, default 5, extra points per hit while combo >= COMBO_TH.
REQ-004 SHALL have parameter COMBO_TH, default 10, combo threshold for bonus.
REQ-005 SHALL have port frame_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port keycode, input, 8, primary keyboard code.
REQ-008 SHALL have port hit, input, N_NOTES, level per dropper: high once the note is scored, low after dropper is halted.
REQ-009 SHALL have port done, input, N_NOTES, level per dropper: high once the note has left play (hit or reached bottom).
REQ-010 SHALL have port score_bcd, output, 16, four BCD digits of total score, digit 3 in [15:12].
REQ-011 SHALL have port combo, output, 8, current consecutive-hit count.
REQ-012 SHALL have port max_combo, output, 8, highest combo this game.
REQ-013 SHALL have port miss_cnt, output, 8, notes missed this game.
REQ-014 SHALL have port game_over, output, 1, high in state Over.

Function
REQ-015 SHALL implement states Idle, Play, Over; Idle->Play on keycode 8'h2c; Play->Over when done is all ones; Over->Idle on keycode 8'h01; otherwise state held.
REQ-016 SHALL clear score_bcd, combo, max_combo, miss_cnt on every Idle->Play transition.
REQ-017 SHALL register hit and done each cycle and detect rising edges only; levels held high SHALL count once.
REQ-018 SHALL ignore edges outside Play; prior-cycle registers SHALL still update so no stale edge fires on entry to Play.
REQ-019 SHALL define a miss for lane i as rising edge of done[i] with hit[i] low in the same cycle.
REQ-020 SHALL count simultaneous events by popcount: H hit edges, M miss edges in one cycle.
REQ-021 SHALL, per cycle with H>0, add H*PTS_HIT plus H*PTS_BONUS if combo (pre-update) >= COMBO_TH, then combo += H.
REQ-022 SHALL, when M>0 in the same cycle, apply hits first, then set combo to 0 and add M to miss_cnt.
REQ-023 SHALL update max_combo to the post-hit combo value (before any miss clear) when it exceeds max_combo.
REQ-024 SHALL make all outputs visible exactly one frame_clk after the input edge cycle (1-cycle latency).
REQ-025 SHALL saturate score_bcd at 16'h9999, combo/max_combo/miss_cnt at 8'hFF; no wrap-around.
REQ-026 SHALL keep score_bcd valid BCD (each digit 0-9) at all times.
REQ-027 SHALL hold all counters unchanged in Over and Idle until the next Play entry.
REQ-028 SHALL give a hit edge and done edge on the same lane in the same cycle credit as a hit, not a miss.

Reset
REQ-029 SHALL on Reset high, asynchronously force state Idle, all outputs 0, edge registers 0.
REQ-030 SHALL, on Reset mid-Play, discard the game; release returns to Idle awaiting 8'h2c.

Structure
REQ-031 SHALL place state enum and key constants (8'h2c start, 8'h01 return) in shared package rhythm_pkg.
REQ-032 SHALL use one sub-module bcd_sat_add: 16-bit BCD plus binary addend up to 9999, saturating, combinational.
REQ-033 SHALL keep popcount and edge detection inside score_tally.

Verification
REQ-034 SHALL test: Play, single hit[3] edge -> next cycle score_bcd=16'h0010, combo=1.
REQ-035 SHALL test: 12 sequential hits -> score_bcd=16'h0130 (10 hits*10 + 2*15), combo=12, max_combo=12.
REQ-036 SHALL test: hit[0] and hit[1] edges with done[2] miss in one cycle, combo 5 -> score +20, combo=0, max_combo=7, miss_cnt+1.
REQ-037 SHALL test: score preloaded near 16'h9990 plus 3 hits -> score_bcd=16'h9999 held.
REQ-038 SHALL test: all done bits high -> game_over=1; keycode 8'h01 -> Idle; 8'h2c -> counters 0, no spurious edge from held levels.
REQ-039 SHALL test: Reset asserted mid-Play between clock edges -> outputs 0 immediately, state Idle.
